hub75_receiver: RTL and testbench
=================================

Name: hub75_receiver

Overview:
Receive-side decoder for the HUB75 panel interface that the matrix driver transmits: R0/G0/B0/R1/G1/B1, A-D, MATCLK, MATLAT, MATOE.
- Models a panel's column shift registers and output latches.
- Converts each latched row into a stream of pixel writes with coordinates, for a shadow framebuffer, loopback self-check or on-board capture.
- Also reports displayed row and protocol errors.

Parameters:
COLS, 32, pixels shifted per row (power of two, 8..128)
ROWS_HALF, 16, rows per half-panel; row address width = clog2(ROWS_HALF)

Ports:
clk  in  1  system clock (50 MHz); all HUB75 inputs are sampled in this domain
rst_n  in  1  asynchronous active-low reset
R0,G0,B0  in  1 each  upper-half serial colour data
R1,G1,B1  in  1 each  lower-half serial colour data
A,B,C,D  in  1 each  row address, A = LSB
MATCLK  in  1  shift clock; data taken on rising edge
MATLAT  in  1  latch; rising edge transfers shift regs to output latches
MATOE  in  1  output enable, active low
pix_valid  out  1  pixel write request
pix_ready  in  1  consumer accepts when pix_valid & pix_ready
pix_x  out  clog2(COLS)  column
pix_y  out  clog2(ROWS_HALF)+1  row (0..2*ROWS_HALF-1)
pix_rgb  out  3  {R,G,B}
disp_on  out  1  registered ~MATOE
disp_row  out  clog2(ROWS_HALF)  row address captured at last latch
err_len  out  1  sticky: latch seen with shift count != COLS
err_ovr  out  1  sticky: latch seen while dump in progress
err_clr  in  1  synchronous clear of both sticky errors

Behaviour:
- Input stage: all HUB75 inputs registered once (s_*), then s_MATCLK/s_MATLAT delayed once more for edge detect. clk_rise = s_MATCLK & ~d_MATCLK; lat_rise likewise.
- Shift: on clk_rise, both COLS-bit shift regs (upper, lower, 3 bits per entry) shift one place toward column COLS-1; the s_* colour bits enter at column 0.
  - Result: after COLS shifts, the first-shifted pixel sits in column COLS-1 and the last in column 0.
- Shift counter: width clog2(COLS)+1, increments on clk_rise, saturates at all-ones, cleared on lat_rise.
- Latch, on lat_rise:
  - If clk_rise occurs in the same cycle, the shift is applied first and the latch captures the post-shift contents; the counter check includes that shift.
  - If count != COLS, set err_len. The latch still occurs.
  - If state is DUMP, set err_ovr and ignore the latch entirely: latches, disp_row and the dump are unaffected.
  - Otherwise copy the shift regs to the latch regs, capture {D,C,B,A} into disp_row, and enter DUMP.
- FSM:
  - IDLE -> DUMP on accepted latch.
  - DUMP: index i runs 0..2*COLS-1. pix_x = i>>1. Even i: upper pixel, pix_y = disp_row. Odd i: lower pixel, pix_y = disp_row + ROWS_HALF.
  - i advances only on pix_valid & pix_ready. After the accepted write at i = 2*COLS-1, return to IDLE.
- Latency and handshake:
  - pix_valid rises the cycle after the lat_rise cycle; first write is 3 clk after the MATLAT pin rises.
  - While pix_valid is high and pix_ready low, pix_x/pix_y/pix_rgb are held stable.
  - pix_valid is never dropped before acceptance.
  - Back-to-back acceptance gives one pixel per clk.
- Shifting continues during DUMP; it does not disturb the latch regs.
- disp_on = registered ~s_MATOE; one cycle after the s_ stage.
- err_clr has priority over a same-cycle set: the errors are cleared.
- Reset values: pix_valid=0, pix_x=0, pix_y=0, pix_rgb=0, disp_on=0, disp_row=0, err_len=0, err_ovr=0. Shift/latch regs and counter are 0, FSM is IDLE.
- Reset asserted mid-DUMP aborts the dump immediately, with no further writes.

Optional Feature:
HUB75_RX_SYNC_EN
- Defined: a 2-flop synchronizer precedes the s_* stage on every HUB75 input, for driving from external pins or another clock. All latencies grow by 2 clk; first write is 5 clk after the MATLAT rise.
- Undefined: single register stage only, for same-clock loopback from the on-chip driver.

Decomposition:
- Shared package hub75_pkg:
  - HUB75_COLS, HUB75_ROWS_HALF defaults
  - derived widths COL_W, ROW_W
  - FSM state typedef {IDLE, DUMP}
  - rgb3 pixel typedef
- One sub-module, hub75_shift_col: one half-panel's COLS x 3 shift register plus output latch.
  - Instantiated twice (upper, lower).
  - Inputs: shift_en, latch_en, din[2:0], rd_idx. Output: dout[2:0].

Test Plan:
- Shift 32 pixels, first pixel R0=1 and the rest 0, then MATLAT with A-D=5 and pix_ready=1 -> 64 back-to-back writes; only (x=31,y=5) rgb=100, all others 0. Lower writes have y=21. err_len=0.
- Same with pix_ready toggling 1/0 every cycle -> 64 writes in exact order (x0y5, x0y21, x1y5, ...), outputs held stable while stalled, no duplicates.
- 31 shifts then latch -> err_len=1 and the dump still occurs. Then assert err_clr -> err_len=0 next cycle. With err_clr and a bad latch in the same cycle -> err_len stays 0.
- Second latch 10 cycles into a dump with pix_ready=0 -> err_ovr=1, first dump completes unchanged, disp_row retains the first row address.
- MATCLK rise and MATLAT rise in the same cycle after 31 prior shifts -> count=32, err_len=0, and the 32nd pixel appears at x=0.
- rst_n pulsed low mid-dump at write 20 -> pix_valid=0 and all errors=0 during and after reset, no further writes, MATOE=0 -> disp_on=1 after re-sampling.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 receive-side decoder: default geometry,
// derived widths, FSM state encoding and the 3-bit pixel type.
package hub75_pkg;

    localparam int HUB75_COLS      = 32;
    localparam int HUB75_ROWS_HALF = 16;

    localparam int COL_W = $clog2(HUB75_COLS);
    localparam int ROW_W = $clog2(HUB75_ROWS_HALF);

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } rx_state_t;

    // {R, G, B}
    typedef logic [2:0] rgb3_t;

endpackage

// File: rtl/hub75_shift_col.sv
// One half-panel worth of column shift register plus output latch.
// New data enters column 0 and moves toward column COLS-1 on each shift.
// A latch in the same cycle as a shift captures the post-shift contents.
module hub75_shift_col
    import hub75_pkg::*;
#(
    parameter int COLS = HUB75_COLS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    shift_en,
    input  logic                    latch_en,
    input  rgb3_t                   din,
    input  logic [$clog2(COLS)-1:0] rd_idx,
    output rgb3_t                   dout
);

    rgb3_t shift_reg  [COLS];
    rgb3_t shift_next [COLS];
    rgb3_t latch_reg  [COLS];

    // Next shift-register contents, one column per generate slice
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            if (gi == 0) begin : g_head
                assign shift_next[gi] = shift_en ? din : shift_reg[gi];
            end else begin : g_body
                assign shift_next[gi] = shift_en ? shift_reg[gi-1] : shift_reg[gi];
            end
        end
    endgenerate

    // Shift register and output latch; latch copies the post-shift view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLS; c++) begin
                shift_reg[c] <= '0;
                latch_reg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < COLS; c++) begin
                shift_reg[c] <= shift_next[c];
                if (latch_en) begin
                    latch_reg[c] <= shift_next[c];
                end
            end
        end
    end

    assign dout = latch_reg[rd_idx];

endmodule

// File: rtl/hub75_receiver.sv
// HUB75 receive-side decoder: models the panel's column shift registers and
// output latches, then replays each latched row as a stream of pixel writes
// (upper and lower half interleaved) through a valid/ready handshake.
// Also reports the displayed row, display enable and protocol errors.
// Optional build macro HUB75_RX_SYNC_EN inserts a 2-flop synchronizer ahead
// of the input register stage (adds 2 clk of latency to everything).
// Row address is taken from the four A-D lines, so ROWS_HALF must be <= 16.
module hub75_receiver
    import hub75_pkg::*;
#(
    parameter int COLS      = HUB75_COLS,
    parameter int ROWS_HALF = HUB75_ROWS_HALF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         R0,
    input  logic                         G0,
    input  logic                         B0,
    input  logic                         R1,
    input  logic                         G1,
    input  logic                         B1,
    input  logic                         A,
    input  logic                         B,
    input  logic                         C,
    input  logic                         D,
    input  logic                         MATCLK,
    input  logic                         MATLAT,
    input  logic                         MATOE,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [$clog2(COLS)-1:0]      pix_x,
    output logic [$clog2(ROWS_HALF):0]   pix_y,
    output logic [2:0]                   pix_rgb,
    output logic                         disp_on,
    output logic [$clog2(ROWS_HALF)-1:0] disp_row,
    output logic                         err_len,
    output logic                         err_ovr,
    input  logic                         err_clr
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS_HALF);
    localparam int CNT_W = CW + 1;
    localparam int IDX_W = CW + 1;
    localparam int IN_W  = 13;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * COLS - 1);

    // MATOE resets high so the display does not appear enabled for a cycle
    // while the input stage refills after reset.
    localparam logic [IN_W-1:0] RST_VEC = IN_W'(1);

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic [IN_W-1:0] hub_raw;
    logic [IN_W-1:0] hub_in;
    logic [IN_W-1:0] s_vec_reg;

    assign hub_raw = {R0, G0, B0, R1, G1, B1, D, C, B, A, MATCLK, MATLAT, MATOE};

`ifdef HUB75_RX_SYNC_EN
    logic [IN_W-1:0] sync1_reg;
    logic [IN_W-1:0] sync2_reg;

    // Two-flop synchronizer for pins driven from outside this clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= RST_VEC;
            sync2_reg <= RST_VEC;
        end else begin
            sync1_reg <= hub_raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign hub_in = sync2_reg;
`else
    assign hub_in = hub_raw;
`endif

    // Single sampling register for all HUB75 inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vec_reg <= RST_VEC;
        end else begin
            s_vec_reg <= hub_in;
        end
    end

    rgb3_t      s_up;
    rgb3_t      s_lo;
    logic [3:0] s_addr;
    logic       s_matclk;
    logic       s_matlat;
    logic       s_matoe;

    assign s_up     = s_vec_reg[12:10];
    assign s_lo     = s_vec_reg[9:7];
    assign s_addr   = s_vec_reg[6:3];
    assign s_matclk = s_vec_reg[2];
    assign s_matlat = s_vec_reg[1];
    assign s_matoe  = s_vec_reg[0];

    logic d_matclk_reg;
    logic d_matlat_reg;
    logic clk_rise;
    logic lat_rise;

    // Second delay on the strobes for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_matclk_reg <= 1'b0;
            d_matlat_reg <= 1'b0;
        end else begin
            d_matclk_reg <= s_matclk;
            d_matlat_reg <= s_matlat;
        end
    end

    assign clk_rise = s_matclk & ~d_matclk_reg;
    assign lat_rise = s_matlat & ~d_matlat_reg;

    // ------------------------------------------------------------------
    // Shift counter: counts shifts since the last latch, saturating
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_seen;

    assign cnt_inc  = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
    // Count as the latch sees it, including a shift in the same cycle
    assign cnt_seen = clk_rise ? cnt_inc : cnt_reg;

    // Counter update: cleared by any latch, otherwise follows shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (lat_rise) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_seen;
        end
    end

    // ------------------------------------------------------------------
    // Dump FSM
    // ------------------------------------------------------------------
    rx_state_t        state_reg;
    rx_state_t        state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;
    logic             latch_en;
    logic             pix_fire;

    assign pix_valid = (state_reg == DUMP);
    assign pix_fire  = pix_valid & pix_ready;

    // State and pixel index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Next state: a latch in IDLE starts a dump; accepted writes walk the index
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        latch_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (lat_rise) begin
                    state_next = DUMP;
                    idx_next   = '0;
                    latch_en   = 1'b1;
                end
            end
            DUMP: begin
                if (pix_fire) begin
                    if (idx_reg == IDX_LAST) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Column shift registers and latches, upper and lower half
    // ------------------------------------------------------------------
    rgb3_t up_dout;
    rgb3_t lo_dout;

    hub75_shift_col #(
        .COLS(COLS)
    ) u_upper (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_en(clk_rise),
        .latch_en(latch_en),
        .din     (s_up),
        .rd_idx  (pix_x),
        .dout    (up_dout)
    );

    hub75_shift_col #(
        .COLS(COLS)
    ) u_lower (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_en(clk_rise),
        .latch_en(latch_en),
        .din     (s_lo),
        .rd_idx  (pix_x),
        .dout    (lo_dout)
    );

    // ------------------------------------------------------------------
    // Row address, display enable and pixel outputs
    // ------------------------------------------------------------------
    logic [RW-1:0] disp_row_reg;
    logic          disp_on_reg;

    // Row address captured only by a latch that starts a dump
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_row_reg <= '0;
        end else if (latch_en) begin
            disp_row_reg <= s_addr[RW-1:0];
        end
    end

    // Display enable, one cycle behind the sampled MATOE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_on_reg <= 1'b0;
        end else begin
            disp_on_reg <= ~s_matoe;
        end
    end

    assign disp_row = disp_row_reg;
    assign disp_on  = disp_on_reg;

    // Even index = upper half, odd index = lower half (row + ROWS_HALF).
    // Everything here derives from registers that are frozen while stalled.
    assign pix_x   = idx_reg[IDX_W-1:1];
    assign pix_y   = idx_reg[0] ? {1'b1, disp_row_reg} : {1'b0, disp_row_reg};
    assign pix_rgb = idx_reg[0] ? lo_dout : up_dout;

    // ------------------------------------------------------------------
    // Sticky protocol errors; clear wins over a same-cycle set
    // ------------------------------------------------------------------
    logic err_len_reg;
    logic err_ovr_reg;

    // Length error on a short/long row, overrun on a latch during a dump
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len_reg <= 1'b0;
            err_ovr_reg <= 1'b0;
        end else if (err_clr) begin
            err_len_reg <= 1'b0;
            err_ovr_reg <= 1'b0;
        end else begin
            if (lat_rise && (cnt_seen != CNT_FULL)) begin
                err_len_reg <= 1'b1;
            end
            if (lat_rise && (state_reg == DUMP)) begin
                err_ovr_reg <= 1'b1;
            end
        end
    end

    assign err_len = err_len_reg;
    assign err_ovr = err_ovr_reg;

endmodule

// File: tb/tb_hub75_receiver.sv
// Self-checking bench for hub75_receiver. A panel model keeps the full
// history of shifted pixels; on each latch the expected row is read from
// that history (column c = pixel shifted c places before the latest) and
// queued as the exact sequence of pixel writes.
module tb_hub75_receiver;

    localparam int COLS = 32;
    localparam int RH   = 16;
`ifdef HUB75_RX_SYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       R0, G0, B0, R1, G1, B1;
    logic       A, B, C, D;
    logic       MATCLK, MATLAT, MATOE;
    logic       pix_valid;
    logic       pix_ready;
    logic [4:0] pix_x;
    logic [4:0] pix_y;
    logic [2:0] pix_rgb;
    logic       disp_on;
    logic [3:0] disp_row;
    logic       err_len;
    logic       err_ovr;
    logic       err_clr;

    always #5 clk = ~clk;

    hub75_receiver #(.COLS(COLS), .ROWS_HALF(RH)) dut (
        .clk(clk), .rst_n(rst_n),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .A(A), .B(B), .C(C), .D(D),
        .MATCLK(MATCLK), .MATLAT(MATLAT), .MATOE(MATOE),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .disp_on(disp_on), .disp_row(disp_row),
        .err_len(err_len), .err_ovr(err_ovr), .err_clr(err_clr)
    );

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic [2:0] rgb;
    } wr_t;

    typedef struct {
        int         n_shifts;
        logic [3:0] addr;
        int         ready_mode;
        logic       exp_err_len;
    } vec_t;

    wr_t        exp_q[$];
    wr_t        wr_log[$];
    logic [2:0] up_hist[$];
    logic [2:0] lo_hist[$];
    int         cnt_m;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard for accepted writes and stall stability
    logic stall_prev = 1'b0;
    wr_t  prev_w;
    always @(negedge clk) begin
        wr_t w;
        wr_t e;
        w = '{x: pix_x, y: pix_y, rgb: pix_rgb};
        if (rst_n && stall_prev) begin
            chk("stall_valid_held", {31'd0, pix_valid}, 32'd1);
            chk("stall_data_held", {19'd0, w}, {19'd0, prev_w});
        end
        if (rst_n && pix_valid && pix_ready) begin
            wr_log.push_back(w);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {19'd0, w}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_data", {19'd0, w}, {19'd0, e});
            end
        end
        stall_prev = rst_n && pix_valid && !pix_ready;
        prev_w     = w;
    end

    task automatic shift_px(input logic [2:0] up, input logic [2:0] lo);
        {R0, G0, B0} = up;
        {R1, G1, B1} = lo;
        MATCLK = 1'b1;
        up_hist.push_back(up);
        lo_hist.push_back(lo);
        cnt_m++;
        tick();
        MATCLK = 1'b0;
        tick();
    endtask

    // Panel model of a latch: returns 1 when the latch starts a dump
    function automatic logic latch_model(input logic [3:0] addr, output logic len_bad);
        int n;
        len_bad = (cnt_m != COLS);
        cnt_m = 0;
        if (exp_q.size() != 0) return 1'b0;
        n = up_hist.size();
        for (int x = 0; x < COLS; x++) begin
            logic [2:0] u;
            logic [2:0] l;
            u = (n - 1 - x >= 0) ? up_hist[n - 1 - x] : 3'b000;
            l = (n - 1 - x >= 0) ? lo_hist[n - 1 - x] : 3'b000;
            exp_q.push_back('{x: 5'(x), y: 5'(addr), rgb: u});
            exp_q.push_back('{x: 5'(x), y: 5'(addr) + 5'(RH), rgb: l});
        end
        return 1'b1;
    endfunction

    task automatic do_latch(input logic [3:0] addr);
        logic bad;
        logic acc;
        {D, C, B, A} = addr;
        MATLAT = 1'b1;
        acc = latch_model(addr, bad);
        tick();
        MATLAT = 1'b0;
    endtask

    task automatic run_dump(input int mode);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ~pix_ready;
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            guard++;
        end
        chk("dump_remaining", exp_q.size(), 0);
        pix_ready = 1'b1;
        repeat (3) tick();
        chk("dump_idle_valid", {31'd0, pix_valid}, 0);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int nz;
        int g;
        logic bad;
        logic acc;
        vecs[0] = '{n_shifts: 32, addr: 4'd3,  ready_mode: 1, exp_err_len: 1'b0};
        vecs[1] = '{n_shifts: 31, addr: 4'd7,  ready_mode: 2, exp_err_len: 1'b1};
        vecs[2] = '{n_shifts: 33, addr: 4'd15, ready_mode: 2, exp_err_len: 1'b1};
        vecs[3] = '{n_shifts: 0,  addr: 4'd0,  ready_mode: 0, exp_err_len: 1'b1};
        vecs[4] = '{n_shifts: 96, addr: 4'd9,  ready_mode: 2, exp_err_len: 1'b1};
        vecs[5] = '{n_shifts: 32, addr: 4'd12, ready_mode: 2, exp_err_len: 1'b0};

        {R0, G0, B0, R1, G1, B1, A, B, C, D} = '0;
        MATCLK = 0; MATLAT = 0; MATOE = 1;
        pix_ready = 0; err_clr = 0; rst_n = 0;
        cnt_m = 0;
        repeat (3) tick();

        // Reset values
        chk("rst_pix_valid", {31'd0, pix_valid}, 0);
        chk("rst_pix_x", {27'd0, pix_x}, 0);
        chk("rst_pix_y", {27'd0, pix_y}, 0);
        chk("rst_pix_rgb", {29'd0, pix_rgb}, 0);
        chk("rst_disp_on", {31'd0, disp_on}, 0);
        chk("rst_disp_row", {28'd0, disp_row}, 0);
        chk("rst_err_len", {31'd0, err_len}, 0);
        chk("rst_err_ovr", {31'd0, err_ovr}, 0);
        rst_n = 1;
        repeat (2) tick();
        chk("oe_high_disp_off", {31'd0, disp_on}, 0);

        // disp_on latency: input register, then output register
        MATOE = 0;
        tick();
        repeat (SX) tick();
        chk("disp_on_early", {31'd0, disp_on}, 0);
        tick();
        chk("disp_on_rise", {31'd0, disp_on}, 1);
        MATOE = 1;
        repeat (2 + SX) tick();
        chk("disp_on_fall", {31'd0, disp_on}, 0);

        // Single red pixel, back-to-back acceptance and first-write latency
        shift_px(3'b100, 3'b000);
        repeat (31) shift_px(3'b000, 3'b000);
        wr_log.delete();
        pix_ready = 1;
        do_latch(4'd5);
        repeat (SX) begin
            chk("lat_wait_sync", {31'd0, pix_valid}, 0);
            tick();
        end
        chk("lat_valid_early", {31'd0, pix_valid}, 0);
        tick();
        chk("lat_valid_rise", {31'd0, pix_valid}, 1);
        repeat (64) tick();
        chk("b2b_count", wr_log.size(), 64);
        chk("b2b_end_valid", {31'd0, pix_valid}, 0);
        nz = 0;
        foreach (wr_log[i]) if (wr_log[i].rgb != 3'b000) nz++;
        chk("single_nonzero", nz, 1);
        chk("red_at_x31_y5", {19'd0, wr_log[62]}, {19'd0, 5'd31, 5'd5, 3'b100});
        chk("lower_row_y21", {27'd0, wr_log[1].y}, 21);
        chk("good_len_no_err", {31'd0, err_len}, 0);
        chk("disp_row_5", {28'd0, disp_row}, 5);

        // Same row with ready toggling every cycle
        shift_px(3'b100, 3'b000);
        repeat (31) shift_px(3'b000, 3'b000);
        wr_log.delete();
        pix_ready = 0;
        do_latch(4'd5);
        run_dump(1);
        chk("toggle_count", wr_log.size(), 64);
        nz = 0;
        foreach (wr_log[i]) if (wr_log[i].x != 5'(i / 2) || wr_log[i].y != ((i % 2) ? 5'd21 : 5'd5)) nz++;
        chk("toggle_order", nz, 0);

        // 31 shifts: length error, dump still runs; then clear
        repeat (31) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        wr_log.delete();
        do_latch(4'd2);
        run_dump(2);
        chk("short_err_len", {31'd0, err_len}, 1);
        chk("short_dump_count", wr_log.size(), 64);
        err_clr = 1;
        tick();
        chk("err_clr_next_cycle", {31'd0, err_len}, 0);
        err_clr = 0;

        // err_clr in the very cycle a bad latch would set the error
        repeat (5) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        do_latch(4'd9);
        repeat (SX) tick();
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("clr_prio", {31'd0, err_len}, 0);
        tick();
        chk("clr_prio_hold", {31'd0, err_len}, 0);
        run_dump(0);

        // Table-driven rows with random data and ready patterns
        for (int v = 0; v < 6; v++) begin
            clear_errs();
            repeat (vecs[v].n_shifts) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            do_latch(vecs[v].addr);
            run_dump(vecs[v].ready_mode);
            chk($sformatf("vec%0d_err_len", v), {31'd0, err_len}, {31'd0, vecs[v].exp_err_len});
            chk($sformatf("vec%0d_err_ovr", v), {31'd0, err_ovr}, 0);
            chk($sformatf("vec%0d_disp_row", v), {28'd0, disp_row}, {28'd0, vecs[v].addr});
        end

        // Latch during a stalled dump: ignored, overrun flagged
        clear_errs();
        pix_ready = 0;
        repeat (32) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        wr_log.delete();
        do_latch(4'd6);
        repeat (10) tick();
        chk("ovr_stall_valid", {31'd0, pix_valid}, 1);
        repeat (32) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        do_latch(4'd11);
        repeat (3 + SX) tick();
        chk("ovr_err_ovr", {31'd0, err_ovr}, 1);
        chk("ovr_err_len", {31'd0, err_len}, 0);
        chk("ovr_disp_row_kept", {28'd0, disp_row}, 6);
        run_dump(0);
        chk("ovr_dump_count", wr_log.size(), 64);
        chk("ovr_sticky", {31'd0, err_ovr}, 1);

        // MATCLK and MATLAT rising together after 31 shifts
        clear_errs();
        repeat (31) shift_px(3'b000, 3'b000);
        wr_log.delete();
        {R0, G0, B0} = 3'b101;
        {R1, G1, B1} = 3'b011;
        up_hist.push_back(3'b101);
        lo_hist.push_back(3'b011);
        cnt_m++;
        {D, C, B, A} = 4'd1;
        MATCLK = 1;
        MATLAT = 1;
        acc = latch_model(4'd1, bad);
        tick();
        MATCLK = 0;
        MATLAT = 0;
        run_dump(0);
        chk("same_cycle_err_len", {31'd0, err_len}, 0);
        chk("same_cycle_x0_up", {19'd0, wr_log[0]}, {19'd0, 5'd0, 5'd1, 3'b101});
        chk("same_cycle_x0_lo", {19'd0, wr_log[1]}, {19'd0, 5'd0, 5'd17, 3'b011});
        chk("same_cycle_x1_up", {29'd0, wr_log[2].rgb}, 0);

        // Reset in the middle of a dump
        clear_errs();
        repeat (20) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        wr_log.delete();
        pix_ready = 1;
        do_latch(4'd4);
        g = 0;
        while (wr_log.size() < 20 && g < 200) begin
            tick();
            g++;
        end
        chk("pre_rst_writes", wr_log.size(), 20);
        chk("pre_rst_err_len", {31'd0, err_len}, 1);
        rst_n = 0;
        MATOE = 0;
        exp_q.delete();
        up_hist.delete();
        lo_hist.delete();
        cnt_m = 0;
        #1;
        chk("rst_async_valid", {31'd0, pix_valid}, 0);
        chk("rst_async_err_len", {31'd0, err_len}, 0);
        chk("rst_async_err_ovr", {31'd0, err_ovr}, 0);
        repeat (2) tick();
        chk("in_rst_valid", {31'd0, pix_valid}, 0);
        chk("in_rst_disp_on", {31'd0, disp_on}, 0);
        rst_n = 1;
        repeat (3 + SX) tick();
        chk("post_rst_disp_on", {31'd0, disp_on}, 1);
        repeat (80) tick();
        chk("post_rst_no_writes", wr_log.size(), 20);
        chk("post_rst_valid", {31'd0, pix_valid}, 0);
        chk("post_rst_err_len", {31'd0, err_len}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
